// File: rtl/maxpool_window_reader_pkg.sv
// Shared CNN pooling-path widths and sizing helpers.
// Imported by the pooling datapath modules.
package maxpool_window_reader_pkg;

   localparam int CNN_BIT_WIDTH = 32;

   // Counter width for a modulus of n, never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/signed_max2.sv
// Two-input signed maximum, purely combinational.
// Ties return a_i; both operands are equal in that case.
module signed_max2
   import maxpool_window_reader_pkg::*;
#(
   parameter int BIT_WIDTH = CNN_BIT_WIDTH
) (
   input  logic [BIT_WIDTH-1:0] a_i,
   input  logic [BIT_WIDTH-1:0] b_i,
   output logic [BIT_WIDTH-1:0] max_o
);

   assign max_o = ($signed(a_i) >= $signed(b_i)) ? a_i : b_i;

endmodule

// File: rtl/maxpool_window_reader.sv
// 2x2 stride-2 signed max pooling over a column-pair stream.
// Emits one result per window with a last-of-map flag.
module maxpool_window_reader
   import maxpool_window_reader_pkg::*;
#(
   parameter int BIT_WIDTH = CNN_BIT_WIDTH,
   parameter int IMG_W     = 28,
   parameter int IMG_H     = 28
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [BIT_WIDTH-1:0] in1,
   input  logic [BIT_WIDTH-1:0] in2,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [BIT_WIDTH-1:0] out_data,
   output logic                 out_last
);

   localparam int CW = cnt_w(IMG_W);
   localparam int RW = cnt_w(IMG_H / 2);

   localparam logic [CW-1:0] COL_END  = CW'(IMG_W - 1);
   localparam logic [CW-1:0] COL_LAST = CW'(2 * (IMG_W / 2) - 1);
   localparam logic [RW-1:0] ROW_END  = RW'(IMG_H / 2 - 1);
   localparam bit            W_ODD    = (IMG_W % 2) == 1;

   logic [CW-1:0]        col_q, col_d;
   logic [RW-1:0]        row_q, row_d;
   logic [BIT_WIDTH-1:0] cmax_q, cmax_d;
   logic [BIT_WIDTH-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 last_q, last_d;

   logic [BIT_WIDTH-1:0] pair_max;
   logic [BIT_WIDTH-1:0] win_max;
   logic                 accept;

   signed_max2 #(.BIT_WIDTH(BIT_WIDTH)) u_pair_max (
      .a_i  (in1),
      .b_i  (in2),
      .max_o(pair_max)
   );

   signed_max2 #(.BIT_WIDTH(BIT_WIDTH)) u_win_max (
      .a_i  (cmax_q),
      .b_i  (pair_max),
      .max_o(win_max)
   );

   assign in_ready  = !valid_q || out_ready;
   assign accept    = in_valid && in_ready;
   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_last  = last_q;

   always_comb begin
      col_d   = col_q;
      row_d   = row_q;
      cmax_d  = cmax_q;
      data_d  = data_q;
      valid_d = valid_q;
      last_d  = last_q;

      if (valid_q && out_ready) begin
         valid_d = 1'b0;
         last_d  = 1'b0;
      end

      if (accept) begin
         if (col_q == COL_END) begin
            col_d = '0;
            row_d = (row_q == ROW_END) ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end

         // Odd column closes a window; the trailing odd-width column is dropped.
         if (col_q[0]) begin
            data_d  = win_max;
            valid_d = 1'b1;
            last_d  = (row_q == ROW_END) && (col_q == COL_LAST);
         end else if (!(W_ODD && col_q == COL_END)) begin
            cmax_d = pair_max;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q   <= '0;
         row_q   <= '0;
         cmax_q  <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         col_q   <= col_d;
         row_q   <= row_d;
         cmax_q  <= cmax_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         last_q  <= last_d;
      end
   end

endmodule

// File: tb/tb_maxpool_window_reader.sv
// Directed bench: 4x4 and 5x2 map instances sharing clock and reset.
// Expected values are hand-computed constants.
module tb_maxpool_window_reader;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in1 = '0;
   logic [7:0] in2 = '0;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [7:0] out_data;
   logic       out_last;

   logic       in_valid2 = 1'b0;
   logic       in_ready2;
   logic [7:0] in1b = '0;
   logic [7:0] in2b = '0;
   logic       out_valid2;
   logic       out_ready2 = 1'b1;
   logic [7:0] out_data2;
   logic       out_last2;

   int pass_cnt = 0;
   int total    = 0;

   logic [7:0] exp4 [4] = '{8'd5, 8'd7, 8'd13, 8'd15};

   always #5 clk = ~clk;

   maxpool_window_reader #(.BIT_WIDTH(8), .IMG_W(4), .IMG_H(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in1      (in1),
      .in2      (in2),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_last (out_last)
   );

   maxpool_window_reader #(.BIT_WIDTH(8), .IMG_W(5), .IMG_H(2)) dut2 (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid2),
      .in_ready (in_ready2),
      .in1      (in1b),
      .in2      (in2b),
      .out_valid(out_valid2),
      .out_ready(out_ready2),
      .out_data (out_data2),
      .out_last (out_last2)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_valid2 = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Present one pair for exactly one edge; returns #1 after that edge.
   task automatic send(input logic [7:0] a, input logic [7:0] b);
      in_valid = 1'b1;
      in1      = a;
      in2      = b;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic send2(input logic [7:0] a, input logic [7:0] b);
      in_valid2 = 1'b1;
      in1b      = a;
      in2b      = b;
      @(posedge clk);
      #1 in_valid2 = 1'b0;
   endtask

   initial begin
      #1 do_reset();
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_data", out_data, 8'd0);
      chk("rst_last", out_last, 1'b0);
      chk("rst_ready", in_ready, 1'b1);

      // Basic window
      send(8'd1, 8'd2);
      chk("t1_no_out", out_valid, 1'b0);
      send(8'd3, -8'sd4);
      chk("t1_valid", out_valid, 1'b1);
      chk("t1_data", out_data, 8'd3);
      chk("t1_last", out_last, 1'b0);

      // Signed compare
      send(-8'sd5, -8'sd6);
      send(-8'sd7, -8'sd3);
      chk("t2_data", out_data, 8'hFD);
      chk("t2_valid", out_valid, 1'b1);

      // Backpressure
      do_reset();
      send(8'd10, 8'd0);
      out_ready = 1'b0;
      send(8'd0, 8'd20);
      chk("t3_data", out_data, 8'd20);
      in_valid = 1'b1;
      in1 = 8'd100;
      in2 = 8'd100;
      for (int i = 0; i < 3; i++) begin
         chk("t3_in_ready", in_ready, 1'b0);
         chk("t3_hold_data", out_data, 8'd20);
         chk("t3_hold_valid", out_valid, 1'b1);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      chk("t3_drained", out_valid, 1'b0);
      send(8'd7, 8'd101);
      chk("t3_resume", out_data, 8'd101);
      chk("t3_resume_last", out_last, 1'b0);

      // Full map twice back to back
      do_reset();
      for (int m = 0; m < 2; m++) begin
         for (int rp = 0; rp < 2; rp++) begin
            for (int c = 0; c < 4; c++) begin
               send(8'(8 * rp + c), 8'(8 * rp + 4 + c));
               if (c % 2 == 1) begin
                  chk("t4_data", out_data, exp4[rp * 2 + c / 2]);
                  chk("t4_last", out_last, (rp == 1 && c == 3) ? 1'b1 : 1'b0);
               end else begin
                  chk("t4_gap", out_valid, 1'b0);
               end
            end
         end
      end

      // Odd width, trailing column discarded
      do_reset();
      send2(8'd1, 8'd1);
      send2(8'd2, 8'd2);
      chk("t5_data0", out_data2, 8'd2);
      chk("t5_last0", out_last2, 1'b0);
      send2(8'd3, 8'd3);
      send2(8'd4, 8'd4);
      chk("t5_data1", out_data2, 8'd4);
      chk("t5_last1", out_last2, 1'b1);
      send2(8'd99, 8'd99);
      chk("t5_discard", out_valid2, 1'b0);
      send2(8'd5, 8'd5);
      chk("t5_wrap_gap", out_valid2, 1'b0);
      send2(8'd6, 8'd6);
      chk("t5_wrap_data", out_data2, 8'd6);
      chk("t5_wrap_last", out_last2, 1'b0);

      // Mid-window reset
      do_reset();
      send(8'd50, 8'd50);
      rst_n = 1'b0;
      #1 chk("t6_in_reset", out_valid, 1'b0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      chk("t6_after_reset", out_valid, 1'b0);
      send(8'd1, 8'd0);
      chk("t6_no_out", out_valid, 1'b0);
      send(8'd0, 8'd2);
      chk("t6_valid", out_valid, 1'b1);
      chk("t6_data", out_data, 8'd2);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
